// File: rtl/twelve_down_counter.sv
// Modulo-MODULUS down counter for the clock's time-setting and countdown path.
// Counts MODULUS-1 down to 0 and wraps back to MODULUS-1. Each wrap produces a
// one-cycle borrow pulse and toggles the half-day flag. A parallel load lets the
// set-time logic preset the count. Out-of-range load values are clamped to the
// top count and flagged with a one-cycle load_err pulse, so out can never hold
// an illegal value.
module twelve_down_counter #(
  parameter int MODULUS = 12,
  parameter int WIDTH   = 4
) (
  input  logic             clockIn,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             borrow,
  output logic [WIDTH-1:0] hour,
  output logic             pm,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MOD_VAL   = WIDTH'(MODULUS);

  // All state updates, with priority reset > load > enable > hold; the pulses default low
  always_ff @(posedge clockIn) begin
    if (!reset) begin
      out      <= '0;
      borrow   <= 1'b0;
      pm       <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      borrow <= 1'b0;
      if (load_val < MOD_VAL) begin
        out      <= load_val;
        load_err <= 1'b0;
      end else begin
        out      <= MAX_COUNT;
        load_err <= 1'b1;
      end
    end else if (en) begin
      load_err <= 1'b0;
      if (out == '0) begin
        out    <= MAX_COUNT;
        borrow <= 1'b1;
        pm     <= ~pm;
      end else begin
        out    <= out - 1'b1;
        borrow <= 1'b0;
      end
    end else begin
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end
  end

  assign z    = (out == '0);
  assign hour = z ? MOD_VAL : out;

endmodule

// File: tb/tb_twelve_down_counter.sv
// Testbench for twelve_down_counter: directed scenarios followed by random
// stimulus, each cycle compared against a behavioural modulo-12 model.
module tb_twelve_down_counter;

  localparam int MODULUS = 12;
  localparam int WIDTH   = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             borrow;
  logic [WIDTH-1:0] hour;
  logic             pm;
  logic             load_err;

  int pass_count = 0;
  int total_count = 0;

  // reference model state, plain integers
  int m_count  = 0;
  int m_pm     = 0;
  int m_borrow = 0;
  int m_err    = 0;

  twelve_down_counter #(.MODULUS(MODULUS), .WIDTH(WIDTH)) dut (
    .clockIn (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .z       (z),
    .borrow  (borrow),
    .hour    (hour),
    .pm      (pm),
    .load_err(load_err)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int actual, input int expected);
    total_count++;
    assert (actual === expected) pass_count++;
    else $error("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
  endtask

  // behavioural update: reset clears, load presets (clamped), enable steps down modulo 12
  task automatic model_edge(input int r, input int e, input int l, input int v);
    if (r == 0) begin
      m_count = 0; m_pm = 0; m_borrow = 0; m_err = 0;
    end else if (l != 0) begin
      m_borrow = 0;
      m_err    = (v >= MODULUS) ? 1 : 0;
      m_count  = (v >= MODULUS) ? MODULUS - 1 : v;
    end else if (e != 0) begin
      m_err    = 0;
      m_borrow = (m_count == 0) ? 1 : 0;
      if (m_borrow == 1) m_pm = 1 - m_pm;
      m_count  = (m_count + MODULUS - 1) % MODULUS;
    end else begin
      m_borrow = 0;
      m_err    = 0;
    end
  endtask

  task automatic apply_stimulus(input int r, input int e, input int l, input int v);
    @(negedge clk);
    reset    = r[0];
    en       = e[0];
    load     = l[0];
    load_val = v[WIDTH-1:0];
    @(posedge clk);
    model_edge(r, e, l, v);
    #1;
    check_output("out",      int'(out),      m_count);
    check_output("z",        int'(z),        (m_count == 0) ? 1 : 0);
    check_output("hour",     int'(hour),     (m_count == 0) ? MODULUS : m_count);
    check_output("borrow",   int'(borrow),   m_borrow);
    check_output("pm",       int'(pm),       m_pm);
    check_output("load_err", int'(load_err), m_err);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;

    // reset wins over simultaneous load and enable
    apply_stimulus(0, 1, 1, 7);
    apply_stimulus(0, 1, 1, 7);
    check_output("reset_hour_12", int'(hour), 12);

    // full cycle: 11,10,...,0,11 with borrow on both wraps
    for (int i = 0; i < 13; i++) apply_stimulus(1, 1, 0, 0);
    check_output("pm_back_to_0", int'(pm), 0);

    // legal load, illegal load clamped, error pulse lasts one cycle
    apply_stimulus(1, 0, 1, 5);
    apply_stimulus(1, 0, 1, 14);
    check_output("clamp_out_11", int'(out), 11);
    apply_stimulus(1, 0, 0, 0);

    // load beats enable at zero: no wrap, pm untouched
    apply_stimulus(1, 0, 1, 0);
    apply_stimulus(1, 1, 1, 3);
    check_output("load_over_en", int'(out), 3);

    // hold at 4, then resume counting
    apply_stimulus(1, 0, 1, 4);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 9);
    apply_stimulus(1, 1, 0, 0);
    check_output("resume_to_3", int'(out), 3);

    // reset mid-operation at zero with enable: no wrap
    apply_stimulus(1, 0, 1, 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("reset_no_wrap", int'(out), 0);

    // randomized traffic, mostly counting
    for (int i = 0; i < 300; i++) begin
      int r, e, l, v;
      r = ($urandom_range(0, 39) == 0) ? 0 : 1;
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      l = ($urandom_range(0, 7) == 0) ? 1 : 0;
      v = $urandom_range(0, 15);
      apply_stimulus(r, e, l, v);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $fatal(1, "[TB] timeout");
  end

endmodule
